// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory handshake bundle between the fetch/decode unit and the instruction memory.
interface fetch_decode_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] imem_address;
  logic                imem_read;
  logic [31:0]         imem_instruction;
  logic                imem_busywait;

  modport master (
    output imem_address,
    output imem_read,
    input  imem_instruction,
    input  imem_busywait
  );

  modport slave (
    input  imem_address,
    input  imem_read,
    output imem_instruction,
    output imem_busywait
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// PC, busywait-driven instruction fetch and decode for the 8-bit single-cycle CPU.
// Optional macro FETCH_PERF_COUNTERS_EN adds retired/stall counters.
module fetch_decode_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_unit_if.master   imem,
  input  logic                  alu_zero,
  output logic [2:0]            inaddress,
  output logic [2:0]            out1address,
  output logic [2:0]            out2address,
  output logic                  write,
  output logic [7:0]            immediate,
  output logic [2:0]            alu_op,
  output logic                  alu_src_imm,
  output logic                  negate,
  output logic                  halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0]           retired_count,
  output logic [15:0]           stall_count
`endif
);

  localparam logic [2:0] ALU_FWD = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [1:0] {
    RESET_HOLD,
    RUN,
    STALL,
    HALT
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic                read_q;

  logic [7:0]          opcode;
  logic                busywait;
  logic                fetching;
  logic                accept;
  logic                legal;
  logic                writes_reg;
  logic                take_branch;
  logic [PC_WIDTH-1:0] pc4;
  logic [PC_WIDTH-1:0] offset_ext;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] next_pc;

  assign opcode    = imem.imem_instruction[31:24];
  assign busywait  = imem.imem_busywait;
  assign fetching  = (state == RUN) || (state == STALL);
  assign accept    = fetching && !busywait;
  assign legal     = (opcode <= 8'h07);

  assign imem.imem_address = pc;
  assign imem.imem_read    = read_q;

  // Branch offsets count instructions, so the sign-extended byte is scaled by 4.
  assign pc4           = pc + PC_WIDTH'(4);
  assign offset_ext    = {{(PC_WIDTH-8){imem.imem_instruction[23]}}, imem.imem_instruction[23:16]};
  assign branch_target = pc4 + (offset_ext << 2);
  assign next_pc       = take_branch ? branch_target : pc4;

  assign write = accept && writes_reg;

  always_comb begin
    inaddress   = imem.imem_instruction[18:16];
    out1address = imem.imem_instruction[10:8];
    out2address = imem.imem_instruction[2:0];
    immediate   = imem.imem_instruction[7:0];
    alu_op      = ALU_FWD;
    alu_src_imm = 1'b0;
    negate      = 1'b0;
    writes_reg  = 1'b0;
    take_branch = 1'b0;
    if (state == RESET_HOLD) begin
      inaddress   = 3'd0;
      out1address = 3'd0;
      out2address = 3'd0;
      immediate   = 8'd0;
    end else begin
      case (opcode)
        8'h00: begin
          writes_reg  = 1'b1;
          alu_src_imm = 1'b1;
        end
        8'h01: writes_reg = 1'b1;
        8'h02: begin
          writes_reg = 1'b1;
          alu_op     = ALU_ADD;
        end
        8'h03: begin
          writes_reg = 1'b1;
          alu_op     = ALU_ADD;
          negate     = 1'b1;
        end
        8'h04: begin
          writes_reg = 1'b1;
          alu_op     = ALU_AND;
        end
        8'h05: begin
          writes_reg = 1'b1;
          alu_op     = ALU_OR;
        end
        8'h06: take_branch = 1'b1;
        8'h07: begin
          alu_op      = ALU_ADD;
          negate      = 1'b1;
          take_branch = alu_zero;
        end
        default: ;
      endcase
    end
  end

  // HALT is only left through reset; the PC never moves while stalled or halted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RESET_HOLD;
      pc     <= RESET_PC;
      halted <= 1'b0;
      read_q <= 1'b0;
    end else begin
      case (state)
        RESET_HOLD: begin
          state  <= RUN;
          read_q <= 1'b1;
        end
        RUN, STALL: begin
          if (busywait) begin
            state <= STALL;
          end else if (legal) begin
            state <= RUN;
            pc    <= next_pc;
          end else begin
            state  <= HALT;
            halted <= 1'b1;
            read_q <= 1'b0;
          end
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count <= 16'd0;
      stall_count   <= 16'd0;
    end else begin
      if (accept && legal && (retired_count != 16'hFFFF))
        retired_count <= retired_count + 16'd1;
      if (fetching && busywait && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: directed instruction stream, queue of expected decodes
// checked by a negedge monitor whenever the unit accepts an instruction.
module tb_fetch_decode_unit;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  in_a;
    logic [2:0]  o1;
    logic [2:0]  o2;
    logic [7:0]  imm;
    logic [2:0]  op;
    logic        src;
    logic        neg;
    logic        wr;
    logic [31:0] next_pc;
    int          kind;
  } exp_t;

  localparam int KIND_FULL    = 0;
  localparam int KIND_JUMP    = 1;
  localparam int KIND_ILLEGAL = 2;

  logic        clk;
  logic        reset;
  logic        alu_zero;
  logic [2:0]  inaddress;
  logic [2:0]  out1address;
  logic [2:0]  out2address;
  logic        write;
  logic [7:0]  immediate;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        negate;
  logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] retired_count;
  logic [15:0] stall_count;
`endif

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  exp_t        cur;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_pc;
  int          pend_kind;

  fetch_decode_unit_if #(.PC_WIDTH(32)) imem_bus ();

  fetch_decode_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .alu_zero    (alu_zero),
    .inaddress   (inaddress),
    .out1address (out1address),
    .out2address (out2address),
    .write       (write),
    .immediate   (immediate),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .negate      (negate),
    .halted      (halted)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .retired_count (retired_count),
    .stall_count   (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] instr, input logic zero, input logic [31:0] pc,
                                input logic [2:0] in_a, input logic [2:0] o1, input logic [2:0] o2,
                                input logic [7:0] imm, input logic [2:0] op, input logic src,
                                input logic neg, input logic wr, input logic [31:0] next_pc,
                                input int kind);
    exp_t e;
    e.pc = pc; e.in_a = in_a; e.o1 = o1; e.o2 = o2; e.imm = imm; e.op = op;
    e.src = src; e.neg = neg; e.wr = wr; e.next_pc = next_pc; e.kind = kind;
    imem_bus.imem_instruction = instr;
    imem_bus.imem_busywait    = 1'b0;
    alu_zero                  = zero;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: verify the PC promised by the previous decode, then score any newly accepted instruction.
  always @(negedge clk) begin
    if (pend_valid) begin
      check_output("next_pc", imem_bus.imem_address, pend_pc);
      if (pend_kind == KIND_ILLEGAL) begin
        check_output("halted_set", 32'(halted), 32'd1);
        check_output("halt_read", 32'(imem_bus.imem_read), 32'd0);
      end
      pend_valid = 1'b0;
    end
    if (reset && imem_bus.imem_read && !imem_bus.imem_busywait) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_accept", imem_bus.imem_address, 32'hFFFF_FFFF);
      end else begin
        cur = exp_q.pop_front();
        check_output("pc", imem_bus.imem_address, cur.pc);
        check_output("write", 32'(write), 32'(cur.wr));
        if (cur.kind != KIND_ILLEGAL) begin
          check_output("inaddress", 32'(inaddress), 32'(cur.in_a));
          check_output("out1address", 32'(out1address), 32'(cur.o1));
          check_output("out2address", 32'(out2address), 32'(cur.o2));
          check_output("immediate", 32'(immediate), 32'(cur.imm));
        end
        if (cur.kind == KIND_FULL) begin
          check_output("alu_op", 32'(alu_op), 32'(cur.op));
          check_output("alu_src_imm", 32'(alu_src_imm), 32'(cur.src));
          check_output("negate", 32'(negate), 32'(cur.neg));
        end
        pend_valid = 1'b1;
        pend_pc    = cur.next_pc;
        pend_kind  = cur.kind;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset                     = 1'b0;
    alu_zero                  = 1'b0;
    imem_bus.imem_instruction = 32'h0;
    imem_bus.imem_busywait    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_address", imem_bus.imem_address, 32'h0);
    check_output("rst_write", 32'(write), 32'd0);
    check_output("rst_read", 32'(imem_bus.imem_read), 32'd0);
    check_output("rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_output("hold_read", 32'(imem_bus.imem_read), 32'd0);
    check_output("hold_write", 32'(write), 32'd0);
    check_output("hold_address", imem_bus.imem_address, 32'h0);
    @(posedge clk);
    #1;
    check_output("run_read", 32'(imem_bus.imem_read), 32'd1);

    // loadi, sub
    apply_stimulus(32'h0002_00FF, 1'b0, 32'h00, 3'd2, 3'd0, 3'd7, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b1, 32'h04, KIND_FULL);
    apply_stimulus(32'h0305_0102, 1'b0, 32'h04, 3'd5, 3'd1, 3'd2, 8'h02, 3'd1, 1'b0, 1'b1, 1'b1, 32'h08, KIND_FULL);

    // three busywait cycles at PC=8
    imem_bus.imem_instruction = 32'h0203_0405;
    imem_bus.imem_busywait    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stall_address", imem_bus.imem_address, 32'h08);
      check_output("stall_write", 32'(write), 32'd0);
      @(posedge clk);
      #1;
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check_output("stall_count", 32'(stall_count), 32'd3);
`endif
    apply_stimulus(32'h0203_0405, 1'b0, 32'h08, 3'd3, 3'd4, 3'd5, 8'h05, 3'd1, 1'b0, 1'b0, 1'b1, 32'h0C, KIND_FULL);
    apply_stimulus(32'h0401_0203, 1'b0, 32'h0C, 3'd1, 3'd2, 3'd3, 8'h03, 3'd2, 1'b0, 1'b0, 1'b1, 32'h10, KIND_FULL);
    // beq -2 taken, or back to 0x10, beq not taken
    apply_stimulus(32'h07FE_0102, 1'b1, 32'h10, 3'd6, 3'd1, 3'd2, 8'h02, 3'd1, 1'b0, 1'b1, 1'b0, 32'h0C, KIND_FULL);
    apply_stimulus(32'h0500_0304, 1'b0, 32'h0C, 3'd0, 3'd3, 3'd4, 8'h04, 3'd3, 1'b0, 1'b0, 1'b1, 32'h10, KIND_FULL);
    apply_stimulus(32'h07FE_0102, 1'b0, 32'h10, 3'd6, 3'd1, 3'd2, 8'h02, 3'd1, 1'b0, 1'b1, 1'b0, 32'h14, KIND_FULL);
    apply_stimulus(32'h0107_0600, 1'b0, 32'h14, 3'd7, 3'd6, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 32'h18, KIND_FULL);
    // j +1 twice, then beq -1 self-loop
    apply_stimulus(32'h0601_0000, 1'b0, 32'h18, 3'd1, 3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 32'h20, KIND_JUMP);
    apply_stimulus(32'h0601_0000, 1'b1, 32'h20, 3'd1, 3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 32'h28, KIND_JUMP);
    apply_stimulus(32'h07FF_0000, 1'b1, 32'h28, 3'd7, 3'd0, 3'd0, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0, 32'h28, KIND_FULL);
    // illegal opcode halts
    apply_stimulus(32'h0900_0000, 1'b0, 32'h28, 3'd0, 3'd0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 32'h28, KIND_ILLEGAL);

    imem_bus.imem_instruction = 32'h0001_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("halt_address", imem_bus.imem_address, 32'h28);
      check_output("halt_write", 32'(write), 32'd0);
      check_output("halt_sticky", 32'(halted), 32'd1);
      check_output("halt_read_low", 32'(imem_bus.imem_read), 32'd0);
      @(posedge clk);
      #1;
    end
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    check_output("retired_count", 32'(retired_count), 32'd11);
    check_output("stall_count_final", 32'(stall_count), 32'd3);
`endif

    #2;
    reset = 1'b0;
    #1;
    check_output("reset_halted", 32'(halted), 32'd0);
    check_output("reset_address", imem_bus.imem_address, 32'h0);
    check_output("reset_read", 32'(imem_bus.imem_read), 32'd0);
    check_output("reset_write", 32'(write), 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    check_output("reset_retired", 32'(retired_count), 32'd0);
    check_output("reset_stalls", 32'(stall_count), 32'd0);
`endif
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
